// File: rtl/l2_d_cache_types.sv
// Shared L2 cache types: line geometry and the memory-side line adapter state encoding.
// Pure declarations; no latency or flow-control behaviour of its own.
package l2_d_cache_types;
  localparam int s_line    = 256;
  localparam int s_offset  = 5;
  localparam int s_beat    = 64;
  localparam int num_beats = s_line / s_beat;
  localparam int beat_w    = $clog2(num_beats);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;
endpackage

// File: rtl/l2_line_buffer.sv
// Line assembly/disassembly register: full-line load or single-beat write per cycle, beat read mux.
// Writes land on the next rising edge; reads are combinational; load wins over a beat write.
module l2_line_buffer
  import l2_d_cache_types::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [s_line-1:0] line_i,
  input  logic              beat_we_i,
  input  logic [beat_w-1:0] beat_idx_i,
  input  logic [s_beat-1:0] beat_i,
  output logic [s_beat-1:0] beat_o,
  output logic [s_line-1:0] line_o
);
  logic [s_line-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (beat_we_i) begin
      line_d[beat_idx_i*s_beat +: s_beat] = beat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_o = line_q[beat_idx_i*s_beat +: s_beat];
  assign line_o = line_q;
endmodule

// File: rtl/l2_cacheline_adapter.sv
// L2 line <-> 4-beat memory burst adapter; line_resp one cycle after the 4th burst_resp, stalls hold outputs.
// Optional perf counters under L2_ADAPTER_PERF_EN; otherwise read_count/write_count are tied to zero.
module l2_cacheline_adapter
  import l2_d_cache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [31:0]       line_address,
  input  logic [s_line-1:0] line_wdata,
  output logic [s_line-1:0] line_rdata,
  output logic              line_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [s_beat-1:0] burst_wdata,
  input  logic [s_beat-1:0] burst_rdata,
  input  logic              burst_resp,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
);
  localparam logic [31:0] offset_mask = 32'((64'd1 << s_offset) - 64'd1);

  adapter_state_t    state_q, state_d;
  logic [beat_w-1:0] beat_q, beat_d;
  logic [31:0]       addr_q, addr_d;
  logic [s_line-1:0] rdata_q, rdata_d;
  logic              buf_load, buf_we, last_beat;
  logic [s_beat-1:0] buf_beat;
  logic [s_line-1:0] buf_line;

  assign last_beat = (beat_q == beat_w'(num_beats - 1));

  l2_line_buffer u_line_buffer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (buf_load),
    .line_i     (line_wdata),
    .beat_we_i  (buf_we),
    .beat_idx_i (beat_q),
    .beat_i     (burst_rdata),
    .beat_o     (buf_beat),
    .line_o     (buf_line)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    buf_load = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          addr_d   = line_address & ~offset_mask;
          beat_d   = '0;
          buf_load = 1'b1;
          state_d  = WRITE;
        end else if (line_read) begin
          addr_d  = line_address & ~offset_mask;
          beat_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (burst_resp) begin
          buf_we = 1'b1;
          beat_d = beat_q + beat_w'(1);
          // Snapshot the finished line so line_rdata survives later write loads.
          if (last_beat) begin
            rdata_d = buf_line;
            rdata_d[s_line-s_beat +: s_beat] = burst_rdata;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (burst_resp) begin
          beat_d = beat_q + beat_w'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign line_resp     = (state_q == DONE);
  assign burst_read    = (state_q == READ);
  assign burst_write   = (state_q == WRITE);
  assign burst_address = addr_q;
  assign burst_wdata   = burst_write ? buf_beat : '0;
  assign line_rdata    = rdata_q;

`ifdef L2_ADAPTER_PERF_EN
  logic        op_wr_q, op_wr_d;
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  assign op_wr_d  = (state_q == IDLE) ? line_write : op_wr_q;
  assign rd_cnt_d = (state_q == DONE && !op_wr_q) ? rd_cnt_q + 32'd1 : rd_cnt_q;
  assign wr_cnt_d = (state_q == DONE &&  op_wr_q) ? wr_cnt_q + 32'd1 : wr_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_wr_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      op_wr_q  <= op_wr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`else
  assign read_count  = '0;
  assign write_count = '0;
`endif
endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Randomized bench for l2_cacheline_adapter against a transaction-level model of lines and beats.
// Honors L2_ADAPTER_PERF_EN for the expected counter values.
module tb_l2_cacheline_adapter;
  logic         clk;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp, burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;
  logic [31:0]  read_count, write_count;

  int n_chk = 0;
  int n_bad = 0;
  logic [255:0] exp_rline;
  int exp_rd, exp_wr;

  l2_cacheline_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp),
    .read_count    (read_count),
    .write_count   (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_counts();
`ifdef L2_ADAPTER_PERF_EN
    chk("read_count", read_count, 256'(exp_rd));
    chk("write_count", write_count, 256'(exp_wr));
`else
    chk("read_count", read_count, 256'd0);
    chk("write_count", write_count, 256'd0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_resp"},  line_resp, 256'd0);
    chk({tag, "_brd"},   burst_read, 256'd0);
    chk({tag, "_bwr"},   burst_write, 256'd0);
    chk({tag, "_baddr"}, burst_address, 256'd0);
    chk({tag, "_bwdat"}, burst_wdata, 256'd0);
    chk({tag, "_rdata"}, line_rdata, 256'd0);
    check_counts();
  endtask

  // Idle cycles with random stray burst_resp that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      line_read   = 1'b0;
      line_write  = 1'b0;
      burst_resp  = 1'($urandom_range(1, 0));
      burst_rdata = {$urandom, $urandom};
      chk("idle_brd", burst_read, 256'd0);
      chk("idle_bwr", burst_write, 256'd0);
      chk("idle_resp", line_resp, 256'd0);
      tick();
    end
    burst_resp = 1'b0;
  endtask

  // One full line transaction; starts and ends in an IDLE cycle, #1 after an edge.
  task automatic do_txn(input bit is_wr, input bit keep_read, input logic [31:0] addr,
                        input logic [255:0] wl, input logic [255:0] rl,
                        input int gmin, input int gmax);
    logic [31:0] exp_addr;
    int gap;
    exp_addr = {addr[31:5], 5'b0};
    chk("start_brd", burst_read, 256'd0);
    chk("start_bwr", burst_write, 256'd0);
    line_write   = is_wr;
    line_read    = !is_wr || keep_read;
    line_address = addr;
    line_wdata   = wl;
    burst_resp   = 1'b0;
    tick();
    line_address = $urandom;
    line_wdata   = rnd256();
    for (int b = 0; b < 4; b++) begin
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g <= gap; g++) begin
        burst_resp  = (g == gap);
        burst_rdata = (g == gap) ? rl[64*b +: 64] : {$urandom, $urandom};
        chk("beat_brd", burst_read, 256'(!is_wr));
        chk("beat_bwr", burst_write, 256'(is_wr));
        chk("beat_addr", burst_address, 256'(exp_addr));
        chk("beat_resp", line_resp, 256'd0);
        if (is_wr) chk("beat_wdata", burst_wdata, 256'(wl[64*b +: 64]));
        tick();
      end
    end
    burst_resp  = 1'($urandom_range(1, 0));
    burst_rdata = {$urandom, $urandom};
    if (!is_wr) exp_rline = rl;
    chk("done_resp", line_resp, 256'd1);
    chk("done_rdata", line_rdata, exp_rline);
    chk("done_brd", burst_read, 256'd0);
    chk("done_bwr", burst_write, 256'd0);
    line_write = 1'b0;
    line_read  = keep_read;
    if (is_wr) exp_wr++;
    else       exp_rd++;
    tick();
    burst_resp = 1'b0;
    chk("post_resp", line_resp, 256'd0);
    chk("post_brd", burst_read, 256'd0);
    check_counts();
  endtask

  initial begin
    bit pend;
    rst = 1'b0; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    exp_rline = '0; exp_rd = 0; exp_wr = 0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    do_txn(1'b0, 1'b0, 32'h8000_005C, 256'd0,
           {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 0);
    do_txn(1'b1, 1'b0, 32'h1234_5678,
           {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}}, 256'd0, 2, 2);

    // Read and write together: the write goes first, the read follows.
    do_txn(1'b1, 1'b1, 32'hCAFE_0020, rnd256(), 256'd0, 0, 1);
    do_txn(1'b0, 1'b0, 32'hCAFE_0020, 256'd0, rnd256(), 0, 1);

    idle_cycles(5);
    do_txn(1'b0, 1'b0, $urandom, 256'd0, rnd256(), 0, 2);

    // Reset after three read beats drops the transaction.
    line_read = 1'b1; line_address = 32'h4000_1000;
    tick();
    for (int b = 0; b < 3; b++) begin
      burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
      tick();
    end
    burst_resp = 1'b0; line_read = 1'b0; rst = 1'b0;
    tick();
    exp_rline = '0; exp_rd = 0; exp_wr = 0;
    check_all_zero("midrst");
    rst = 1'b1;
    idle_cycles(2);
    do_txn(1'b0, 1'b0, 32'h4000_1000, 256'd0, rnd256(), 0, 0);

    pend = 1'b0;
    repeat (40) begin
      bit w, k;
      w = pend ? 1'b0 : 1'($urandom_range(1, 0));
      k = w && ($urandom_range(3, 0) == 0);
      do_txn(w, k, $urandom, rnd256(), rnd256(), 0, 3);
      pend = k;
      if (!k && $urandom_range(3, 0) == 0) idle_cycles($urandom_range(3, 1));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
